mealy_seq_detector: RTL and testbench
=====================================

Name: mealy_seq_detector

Overview:
- Parametrised Mealy-style serial pattern detector; next generation of the team's 3-process Mealy FSM.
- Matches an N-bit pattern on a serial input qualified by a valid strobe, with overlap or non-overlap mode.
- Drives a combinational Mealy match output and a saturating match counter.
- Sits behind serial front-ends, for example frame-sync or preamble detection.

Parameters:
- N, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, N-bit pattern; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = detector restarts from empty after each match.
- CNT_W, 8, width of the match counter.
- SW, $clog2(N+1), state width (derived localparam, not overridable).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  detector enable; 0 = synchronous soft clear to IDLE.
- din_valid  in  1  qualifies din; a bit is consumed only when din_valid=1.
- din  in  1  serial data bit.
- dout  out  1  Mealy match pulse (combinational).
- match_cnt  out  CNT_W  saturating count of matches.
- p_state  out  SW  present state (debug).
- n_state  out  SW  next state (debug, combinational).

Behaviour:
- Architecture: three processes:
  - state register with async reset;
  - combinational output decoder;
  - combinational next-state decoder.
- State encoding:
  - 0 = IDLE.
  - k+1 = Mk, meaning k pattern bits matched, for k=0..N-1.
- Reset (rst=1, asynchronous, immediate, held while high): p_state=IDLE, match_cnt=0, dout=0.
- IDLE:
  - dout=0; din and din_valid are ignored.
  - en=1 -> next state M0; en=0 -> stay in IDLE.
  - One cycle is always spent in IDLE after reset or soft clear.
- en=0 in any state: n_state=IDLE, dout=0, match_cnt holds its value.
- Mk with en=1 and din_valid=0: state holds, dout=0.
- Mk with en=1 and din_valid=1 (an accepted bit), for k<N-1:
  - next = Mj, where j is the largest value ≤ k+1 such that the first j bits of PATTERN equal the last j bits of (first k bits of PATTERN followed by din).
  - This is a KMP fallback computed from PATTERN only; no history register is needed.
- M(N-1) with an accepted bit and din == PATTERN[0] (full match):
  - dout=1 in the same cycle (Mealy, zero latency from din).
  - match_cnt increments at that clock edge and saturates at 2^CNT_W-1.
  - Next state: OVERLAP=1 -> Mb, where b is the longest proper prefix of PATTERN that is also a suffix; OVERLAP=0 -> M0.
- M(N-1) with an accepted bit that mismatches: same fallback rule as the k<N-1 case, with dout=0.
- dout is high only for a full match with en=1, din_valid=1 and state M(N-1).
- dout may glitch with din; consumers must sample it at clk.
- Unreachable encodings (values above N): n_state=IDLE, dout=0.
- Simultaneous events: rst overrides everything; en=0 overrides din_valid, so a match during en=0 is neither output nor counted.
- Fallback tables are elaborated from parameters at compile time; there is no runtime pattern load.

Test Plan:
- All scenarios use N=4, PATTERN=1011, CNT_W=8 unless stated otherwise.
1. Basic match:
   - Stimulus: release rst, en=1; one cycle in IDLE; then accepted bits 1,0,1,1.
   - Required: dout=1 only during the 4th bit cycle; match_cnt=1 after that edge.
   - Required p_state sequence: 0,1,2,3,4,then 2.
2. Overlap:
   - Stimulus: bits 1,0,1,1,0,1,1.
   - Required with OVERLAP=1: dout pulses on bits 4 and 7; match_cnt=2.
   - Required with OVERLAP=0: pulse on bit 4 only; match_cnt=1.
3. Fallback:
   - Stimulus: bits 1,0,1,0,1,1.
   - Required: the 4th bit (0) moves the state M3 -> M2; single dout pulse on bit 6.
4. Valid gaps:
   - Stimulus: 1,0,[din_valid=0 with din=1 for 3 cycles],1,1.
   - Required: state frozen and dout=0 during the gap; match on the final bit.
5. Soft clear:
   - Stimulus: 1,0,1 then en=0 for 1 cycle, then en=1 with 1 idle cycle, then 1,0,1,1.
   - Required: no match from the first fragment; match on the final sequence; match_cnt holds across the clear.
6. Async reset and saturation:
   - Stimulus: assert rst mid-pattern between clock edges.
   - Required: p_state=0 and match_cnt=0 immediately, without waiting for a clock edge.
   - Stimulus: CNT_W=2 and 5 matches.
   - Required: match_cnt=3.

Source files
------------

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector with a parameter-elaborated KMP fallback
// table, optional overlapping matches and a saturating match counter.
// State encoding: 0 = IDLE, k+1 = "k pattern bits matched" for k = 0..N-1.
module mealy_seq_detector #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8,
   localparam int            SW      = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din_valid,
   input  logic             din,
   output logic             dout,
   output logic [CNT_W-1:0] match_cnt,
   output logic [SW-1:0]    p_state,
   output logic [SW-1:0]    n_state
);

   localparam logic [SW-1:0] IDLE  = '0;
   localparam logic [SW-1:0] FIRST = SW'(1);
   localparam logic [SW-1:0] LAST  = SW'(N);
   localparam int            TBL_W = 2 * N * SW;

   // Longest proper prefix of PATTERN that is also a suffix of it.
   function automatic int border_len();
      int best;
      bit ok;
      best = 0;
      for (int j = 1; j < N; j++) begin
         ok = 1'b1;
         for (int i = 0; i < j; i++)
            if (PATTERN[N-1-i] != PATTERN[j-1-i]) ok = 1'b0;
         if (ok) best = j;
      end
      return best;
   endfunction

   // Next-state table for every (matched count k, received bit b) pair.
   // Entry (k,b) sits at bit offset (2*k+b)*SW and holds an encoded state.
   function automatic logic [TBL_W-1:0] build_table();
      logic [TBL_W-1:0] tbl;
      logic [15:0]      seq;   // seq[0] is the oldest bit of the window
      int               nxt;
      bit               ok;
      tbl = '0;
      for (int k = 0; k < N; k++) begin
         for (int b = 0; b < 2; b++) begin
            seq = '0;
            for (int i = 0; i < k; i++) seq[i] = PATTERN[N-1-i];
            seq[k] = b[0];
            if (k == N - 1 && b[0] == PATTERN[0]) begin
               nxt = OVERLAP ? border_len() : 0;
            end else begin
               nxt = 0;
               for (int j = 1; j <= k + 1; j++) begin
                  ok = 1'b1;
                  for (int i = 0; i < j; i++)
                     if (PATTERN[N-1-i] != seq[k+1-j+i]) ok = 1'b0;
                  if (ok) nxt = j;
               end
            end
            tbl[(2*k+b)*SW +: SW] = SW'(nxt + 1);
         end
      end
      return tbl;
   endfunction

   localparam logic [TBL_W-1:0] NXT_TBL = build_table();

   int idx;

   // State register and saturating match counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_state   <= IDLE;
         match_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, independent of statement order.
         p_state <= n_state;
         if (dout && match_cnt != '1)
            match_cnt <= match_cnt + 1'b1;
      end
   end

   // Mealy output decoder: full match on the last bit of the pattern
   always_comb begin
      // NOTE: a default before any condition guarantees no latch is inferred.
      dout = 1'b0;
      if (en && din_valid && p_state == LAST && din == PATTERN[0])
         dout = 1'b1;
   end

   // Next-state decoder: soft clear, IDLE exit, table-driven fallback
   always_comb begin
      n_state = p_state;
      idx     = 0;
      if (!en) begin
         n_state = IDLE;
      end else if (p_state == IDLE) begin
         n_state = FIRST;
      end else if (p_state > LAST) begin
         n_state = IDLE;
      end else if (din_valid) begin
         idx     = 2 * (int'(p_state) - 1) + int'(din);
         n_state = NXT_TBL[idx*SW +: SW];
      end
   end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench for mealy_seq_detector: three instances (overlap,
// non-overlap, 2-bit counter) share stimulus and are compared against a
// history-based reference model.
module tb_mealy_seq_detector;

   localparam int          N   = 4;
   localparam logic [3:0]  PAT = 4'b1011;

   logic       clk = 1'b0;
   logic       rst, en, din_valid, din;
   logic       dout_ov, dout_nov, dout_sat;
   logic [7:0] cnt_ov, cnt_nov;
   logic [1:0] cnt_sat;
   logic [2:0] ps_ov, ns_ov, ps_nov, ns_nov, ps_sat, ns_sat;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit          m_idle;
   logic [31:0] h_ov, h_nov;
   int          l_ov, l_nov;
   int          c_ov, c_nov, c_sat;

   // values captured in the cycle just executed
   logic [2:0]  pre_p;
   logic        pre_dout, pre_dout_nov;

   always #5 clk = ~clk;

   mealy_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
      .dout(dout_ov), .match_cnt(cnt_ov), .p_state(ps_ov), .n_state(ns_ov));

   mealy_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
      .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
      .dout(dout_nov), .match_cnt(cnt_nov), .p_state(ps_nov), .n_state(ns_nov));

   mealy_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
      .dout(dout_sat), .match_cnt(cnt_sat), .p_state(ps_sat), .n_state(ns_sat));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Longest suffix of the received history (shorter than N) that is a
   // prefix of the pattern; the newest bit is history bit 0.
   function automatic int kmp_len(input logic [31:0] h, input int len);
      int best = 0;
      for (int j = 1; j < N; j++)
         if (j <= len && ((h & ((32'd1 << j) - 32'd1)) == (32'(PAT) >> (N - j))))
            best = j;
      return best;
   endfunction

   function automatic logic [31:0] exp_state(input logic [31:0] h, input int len);
      return m_idle ? 32'd0 : 32'(kmp_len(h, len) + 1);
   endfunction

   function automatic bit completes(input logic [31:0] h, input int len, input logic d);
      logic [31:0] nh;
      nh = {h[30:0], d};
      return (len + 1 >= N) && (nh[N-1:0] == PAT);
   endfunction

   task automatic model_clear();
      m_idle = 1'b1;
      h_ov = '0; l_ov = 0; h_nov = '0; l_nov = 0;
      c_ov = 0; c_nov = 0; c_sat = 0;
   endtask

   // One clock cycle: drive at negedge, check combinational outputs before
   // the edge, advance the model, check registered outputs after the edge.
   task automatic cyc(input logic e, input logic v, input logic d);
      bit         x_ov, x_nov;
      logic [2:0] ns_ov_s, ns_nov_s, ns_sat_s;
      en = e; din_valid = v; din = d;
      #1;
      x_ov  = !m_idle && e && v && completes(h_ov, l_ov, d);
      x_nov = !m_idle && e && v && completes(h_nov, l_nov, d);
      check("dout_ov",  32'(dout_ov),  32'(x_ov));
      check("dout_nov", 32'(dout_nov), 32'(x_nov));
      check("dout_sat", 32'(dout_sat), 32'(x_ov));
      check("p_state_ov",  32'(ps_ov),  exp_state(h_ov, l_ov));
      check("p_state_nov", 32'(ps_nov), exp_state(h_nov, l_nov));
      check("p_state_sat", 32'(ps_sat), exp_state(h_ov, l_ov));
      pre_p = ps_ov; pre_dout = dout_ov; pre_dout_nov = dout_nov;
      ns_ov_s = ns_ov; ns_nov_s = ns_nov; ns_sat_s = ns_sat;
      @(posedge clk);
      if (!e) begin
         m_idle = 1'b1;
      end else if (m_idle) begin
         m_idle = 1'b0;
         h_ov = '0; l_ov = 0; h_nov = '0; l_nov = 0;
      end else if (v) begin
         if (x_ov) begin
            c_ov  = (c_ov < 255) ? c_ov + 1 : 255;
            c_sat = (c_sat < 3) ? c_sat + 1 : 3;
         end
         if (x_nov) c_nov = (c_nov < 255) ? c_nov + 1 : 255;
         h_ov = {h_ov[30:0], d};
         l_ov = (l_ov < 31) ? l_ov + 1 : 31;
         if (x_nov) begin
            h_nov = '0; l_nov = 0;
         end else begin
            h_nov = {h_nov[30:0], d};
            l_nov = (l_nov < 31) ? l_nov + 1 : 31;
         end
      end
      #1;
      check("n_state_ov",  32'(ns_ov_s),  exp_state(h_ov, l_ov));
      check("n_state_nov", 32'(ns_nov_s), exp_state(h_nov, l_nov));
      check("n_state_sat", 32'(ns_sat_s), exp_state(h_ov, l_ov));
      check("cnt_ov",  32'(cnt_ov),  32'(c_ov));
      check("cnt_nov", 32'(cnt_nov), 32'(c_nov));
      check("cnt_sat", 32'(cnt_sat), 32'(c_sat));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      logic [3:0] b4;
      logic [6:0] b7;
      logic [5:0] b6;
      logic [6:0] mask_ov, mask_nov;
      logic [5:0] mask6;

      rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = 1'b0;
      model_clear();
      @(negedge clk);
      check("reset_p_state", 32'(ps_ov), 32'd0);
      check("reset_cnt", 32'(cnt_ov), 32'd0);
      check("reset_dout", 32'(dout_ov), 32'd0);
      rst = 1'b0;

      // Basic match, with din_valid/din ignored during the IDLE cycle
      cyc(1'b1, 1'b1, 1'b1);
      check("t1_idle_p", 32'(pre_p), 32'd0);
      b4 = 4'b1011;
      for (int s = 0; s < 4; s++) begin
         cyc(1'b1, 1'b1, b4[3-s]);
         check("t1_p_seq", 32'(pre_p), 32'(s + 1));
         check("t1_dout", 32'(pre_dout), 32'(s == 3));
      end
      check("t1_p_after", 32'(ps_ov), 32'd2);
      check("t1_cnt", 32'(cnt_ov), 32'd1);

      // Overlapping vs non-overlapping matches
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      b7 = 7'b1011011;
      mask_ov = '0; mask_nov = '0;
      for (int s = 0; s < 7; s++) begin
         cyc(1'b1, 1'b1, b7[6-s]);
         mask_ov[s]  = pre_dout;
         mask_nov[s] = pre_dout_nov;
      end
      check("t2_pulses_ov", 32'(mask_ov), 32'h48);
      check("t2_pulses_nov", 32'(mask_nov), 32'h08);
      check("t2_cnt_ov", 32'(cnt_ov), 32'd2);
      check("t2_cnt_nov", 32'(cnt_nov), 32'd1);

      // KMP fallback from M3 to M2
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      b6 = 6'b101011;
      mask6 = '0;
      for (int s = 0; s < 6; s++) begin
         cyc(1'b1, 1'b1, b6[5-s]);
         mask6[s] = pre_dout;
         if (s == 3) check("t3_fallback_state", 32'(ps_ov), 32'd3);
      end
      check("t3_pulses", 32'(mask6), 32'h20);
      check("t3_cnt", 32'(cnt_ov), 32'd1);

      // Valid gaps freeze the state
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0);
      for (int s = 0; s < 3; s++) begin
         cyc(1'b1, 1'b0, 1'b1);
         check("t4_gap_p", 32'(pre_p), 32'd3);
         check("t4_gap_dout", 32'(pre_dout), 32'd0);
      end
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      check("t4_match", 32'(pre_dout), 32'd1);
      check("t4_cnt", 32'(cnt_ov), 32'd1);

      // Soft clear: en=0 while a completing bit is presented
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      check("t5_clear_dout", 32'(pre_dout), 32'd0);
      check("t5_clear_p", 32'(ps_ov), 32'd0);
      check("t5_cnt_hold", 32'(cnt_ov), 32'd1);
      cyc(1'b1, 1'b1, 1'b1);
      check("t5_idle_p", 32'(pre_p), 32'd0);
      b4 = 4'b1011;
      for (int s = 0; s < 4; s++) cyc(1'b1, 1'b1, b4[3-s]);
      check("t5_match", 32'(pre_dout), 32'd1);
      check("t5_cnt", 32'(cnt_ov), 32'd2);

      // Asynchronous reset between clock edges, mid-pattern
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0);
      en = 1'b1; din_valid = 1'b1; din = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      check("t6_async_p", 32'(ps_ov), 32'd0);
      check("t6_async_cnt", 32'(cnt_ov), 32'd0);
      check("t6_async_cnt_nov", 32'(cnt_nov), 32'd0);
      check("t6_async_dout", 32'(dout_ov), 32'd0);
      @(negedge clk);
      check("t6_hold_p", 32'(ps_ov), 32'd0);
      rst = 1'b0;
      model_clear();

      // Saturation of the 2-bit counter after five matches
      cyc(1'b1, 1'b0, 1'b0);
      for (int r = 0; r < 5; r++)
         for (int s = 0; s < 4; s++) cyc(1'b1, 1'b1, b4[3-s]);
      check("t6_sat_cnt", 32'(cnt_sat), 32'd3);
      check("t6_cnt_ov", 32'(cnt_ov), 32'd5);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 500; i++)
         cyc(logic'($urandom_range(0, 15) != 0),
             logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
